// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell walks the operands LSB-first,
// one bit per clock, behind a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;

  logic             w_s;
  logic             w_cn;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_next;

  always_comb begin
    w_next     = r_state;
    w_last     = (r_cnt == CW'(WIDTH - 1));
    w_s        = r_a[0] ^ r_b[0] ^ r_c;
    w_cn       = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    w_acc_next = r_acc >> 1;
    w_acc_next[WIDTH-1] = w_s;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: invert b and force the carry-in.
            r_a   <= a;
            r_b   <= sub ? ~b : b;
            r_c   <= sub ? 1'b1 : cin;
            r_cnt <= '0;
            r_acc <= '0;
          end
        end
        RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_cn;
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            // r_c is the carry into the MSB on this last step.
            r_sum  <= w_acc_next;
            r_cout <= w_cn;
            r_ovf  <= r_c ^ w_cn;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for add/sub/handshake/reset
// cases and a 1-bit instance for the full-adder truth table.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic       cin8, sub8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  logic [0:0] a1, b1, sum1;
  logic       cin1, sub1, busy1, done1, cout1, ovf1;

  int n_total = 0;
  int n_bad   = 0;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // Launch one 8-bit op, then walk the cycles after acceptance until done.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic cin, input logic sub,
                     input logic [7:0] es, input logic ec, input logic eo);
    int n;
    int nbusy;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    a8 = ~a; b8 = ~b; cin8 = ~cin; sub8 = ~sub;
    n = 0; nbusy = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy8) nbusy++;
    end while (!done8 && n < 40);
    chk({tag, "_lat"}, 64'(n), 64'd9);
    chk({tag, "_busy"}, 64'(nbusy), 64'd8);
    chk({tag, "_sum"}, 64'(sum8), 64'(es));
    chk({tag, "_cout"}, 64'(cout8), 64'(ec));
    chk({tag, "_ovf"}, 64'(ovf8), 64'(eo));
  endtask

  task automatic op1(input string tag, input logic a, input logic b, input logic cin,
                     input logic es, input logic ec);
    int n;
    @(negedge clk);
    a1 = a; b1 = b; cin1 = cin; sub1 = 1'b0; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done1 && n < 20);
    chk({tag, "_lat"}, 64'(n), 64'd2);
    chk({tag, "_sum"}, 64'(sum1), 64'(es));
    chk({tag, "_cout"}, 64'(cout1), 64'(ec));
    chk({tag, "_ovf"}, 64'(ovf1), 64'(ec ^ cin));
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_sum", 64'(sum8), 64'd0);
    chk("rst_cout", 64'(cout8), 64'd0);
    chk("rst_ovf", 64'(ovf8), 64'd0);

    // Additions
    op8("add_zero", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    op8("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("add_ovf",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("add_cin",  8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);

    // Subtractions
    op8("sub_neg",  8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    op8("sub_ovf",  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    op8("sub_eq",   8'h07, 8'h07, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);

    // start held for 20 cycles, operands change mid-op
    @(negedge clk);
    a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 3) begin a8 = 8'h11; b8 = 8'h22; end
      chk($sformatf("hold_done_%0d", k), 64'(done8), 64'((k == 9) || (k == 19)));
      if (k == 9)  chk("hold_sum1", 64'(sum8), 64'h07);
      if (k == 10) chk("hold_idle_busy", 64'(busy8), 64'd0);
      if (k == 19) begin
        chk("hold_sum2", 64'(sum8), 64'h33);
        start8 = 1'b0;
      end
    end

    // Reset in the middle of a RUN
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 4) rst = 1'b1;
      if (k == 5) begin
        chk("abort_busy", 64'(busy8), 64'd0);
        chk("abort_done", 64'(done8), 64'd0);
        chk("abort_sum", 64'(sum8), 64'd0);
        chk("abort_cout", 64'(cout8), 64'd0);
        chk("abort_ovf", 64'(ovf8), 64'd0);
        rst = 1'b0;
      end
    end
    op8("after_rst", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

    // start coinciding with rst is dropped
    @(negedge clk);
    rst = 1'b1; start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0;
    chk("rst_start_busy", 64'(busy8), 64'd0);
    @(negedge clk);
    chk("rst_start_busy2", 64'(busy8), 64'd0);

    // WIDTH=1 full-adder truth table
    op1("fa000", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    op1("fa001", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    op1("fa010", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    op1("fa011", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    op1("fa100", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    op1("fa101", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    op1("fa110", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    op1("fa111", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised bit-serial adder/subtractor. It applies a single full-adder cell to the operands LSB-first, one bit per clock, and accumulates a WIDTH-bit sum, carry-out and signed overflow. It is the sequential successor to the single-bit full adder, and is used wherever multi-bit add/sub is needed at minimal area and latency is acceptable. Operands are accepted through a start/busy/done handshake.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1..64. Iteration counter width is $clog2(WIDTH+1).

Ports:
clk  input  1  single clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
cin  input  1  carry-in; captured on accepted start; ignored when sub=1
sub  input  1  0 = add (a+b+cin), 1 = subtract (a+~b+1); captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  result
cout  output  1  carry out of MSB; for subtract, 1 = no borrow (a >= b unsigned)
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset: state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; shift registers and counter cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at edge T -> latch a, b (inverted if sub), carry register (cin if add, 1 if sub), mode; counter=0; go to RUN. busy=1 from T+1.
- RUN: each cycle processes bit i=counter. Computes s_i = a_i^b'_i^c and c_next = majority(a_i, b'_i, c). Shifts s_i into the MSB of the result shift register (after WIDTH shifts, bit 0 is at LSB). Records the carry into bit i when i=WIDTH-1. counter increments.
- RUN lasts exactly WIDTH cycles (T+1..T+WIDTH). On the last RUN edge, sum/cout/ovf registers load together and the state moves to DONE.
- DONE (cycle T+WIDTH+1): done=1, busy=0. Unconditionally return to IDLE next edge.
- Total latency: start accepted at T -> done=1 at T+WIDTH+1. Back-to-back throughput is one op per WIDTH+2 cycles.
- sum/cout/ovf hold their value until the next op's final RUN edge. They are not cleared by start.
- start in RUN or DONE: ignored entirely. Latched operands and outputs are unaffected; no queuing.
- Input changes on a/b/cin/sub after acceptance: no effect on the op in flight.
- WIDTH=1: RUN is one cycle. Carry into MSB = captured carry-in, so ovf = cin' XOR cout.
- rst during any state, including mid-RUN: the next cycle is IDLE with all outputs 0. The aborted op never asserts done. A start sampled in the same cycle as rst is dropped (reset wins).
- Arithmetic is modulo 2^WIDTH; no saturation.

Test Plan:
1. WIDTH=8, add a=0x00 b=0x00 cin=0, start at T -> busy high T+1..T+8; done=1 only at T+9; sum=0x00 cout=0 ovf=0.
2. WIDTH=8, add a=0xFF b=0x01 cin=0 -> sum=0x00 cout=1 ovf=0. Then add a=0x7F b=0x01 cin=0 -> sum=0x80 cout=0 ovf=1. Then add a=0x7F b=0x00 cin=1 -> sum=0x80 ovf=1.
3. WIDTH=8, subtract a=0x05 b=0x07 -> sum=0xFE cout=0 ovf=0. Subtract a=0x80 b=0x01 -> sum=0x7F cout=1 ovf=1. Subtract a=0x07 b=0x07 with cin=0 -> sum=0x00 cout=1 (cin ignored).
4. WIDTH=8, start held high for 20 cycles; operands change to a=0x11 b=0x22 at T+3 -> first result from the T-captured operands at T+9. A second op is accepted only at the IDLE edge T+10, with done at T+19.
5. WIDTH=8, rst asserted one cycle at T+4 of a RUN -> busy=0, sum=0, cout=0, ovf=0 at T+5; no done pulse. A new start at T+6 completes normally at T+15.
6. WIDTH=1, all 8 combinations of a, b, cin (add mode) -> {cout, sum} equals the full-adder truth table (e.g. 1,1,1 -> sum=1 cout=1). Each done occurs exactly 2 cycles after start.
